// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - load stream and fetch port bundle for imem_loadable
interface imem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instruction;
    logic              instr_oob;

    // host / fetch-stage side
    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready, load_done, load_count,
        output fetch_req, fetch_addr,
        input  fetch_ready, instr_valid, instruction, instr_oob
    );

    // memory side
    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready, load_done, load_count,
        input  fetch_req, fetch_addr,
        output fetch_ready, instr_valid, instruction, instr_oob
    );
endinterface

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - stream-loaded instruction RAM with registered fetch; IMEM_WRAP_EN wraps fetch addresses modulo DEPTH
module imem_loadable #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                DEPTH  = 32,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_loadable_if.slave bus
);
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wptr_q;
    logic [ADDR_W:0]   count_q;
    logic              done_q;
    logic              valid_q;
    logic              oob_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              load_begin;
    logic              load_end;
    logic              fetch_acc;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_oob;

    assign bus.load_ready  = (state_q == LOAD);
    assign bus.fetch_ready = (state_q == RUN);
    assign bus.load_done   = done_q;
    assign bus.load_count  = count_q;
    assign bus.instr_valid = valid_q;
    assign bus.instruction = instr_q;
    assign bus.instr_oob   = oob_q;

    assign fetch_acc = bus.fetch_req && (state_q == RUN);

`ifdef IMEM_WRAP_EN
    assign rd_idx = IDX_W'({1'b0, bus.fetch_addr} % DEPTH_EXT);
    assign rd_oob = 1'b0;
`else
    assign rd_idx = bus.fetch_addr[IDX_W-1:0];
    assign rd_oob = ({1'b0, bus.fetch_addr} >= DEPTH_EXT);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and load-path strobes; a load ends on load_last or when the array is full
    always_comb begin
        state_d    = state_q;
        wr_en      = 1'b0;
        load_begin = 1'b0;
        load_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d    = LOAD;
                    load_begin = 1'b1;
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    wr_en = 1'b1;
                    if (bus.load_last || (wptr_q == LAST_IDX)) begin
                        state_d  = RUN;
                        load_end = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    state_d    = LOAD;
                    load_begin = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // write pointer, load bookkeeping and the registered fetch result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            done_q  <= load_end;
            valid_q <= fetch_acc;
            if (load_begin) begin
                wptr_q  <= '0;
                count_q <= '0;
            end else if (wr_en) begin
                wptr_q  <= wptr_q + IDX_W'(1);
                count_q <= (ADDR_W + 1)'(wptr_q) + ONE_CNT;
            end
            if (fetch_acc) begin
                instr_q <= rd_oob ? FILL : mem[rd_idx];
                oob_q   <= rd_oob;
            end
        end
    end

    // storage array: never cleared, and a write in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wptr_q] <= bus.load_data;
        end
    end
endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - randomized self-checking bench for imem_loadable
module tb_imem_loadable;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    imem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_loadable #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .FILL  (8'h00)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [DEPTH];
    int         ref_count = 0;
    logic [7:0] ref_instr = 8'h00;
    logic       ref_oob = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
    endtask

    function automatic void predict_fetch(input int addr);
`ifdef IMEM_WRAP_EN
        ref_instr = ref_mem[addr % DEPTH];
        ref_oob   = 1'b0;
`else
        if (addr >= DEPTH) begin
            ref_instr = 8'h00;
            ref_oob   = 1'b1;
        end else begin
            ref_instr = ref_mem[addr];
            ref_oob   = 1'b0;
        end
`endif
    endfunction

    task automatic check_fetch(input string tag, input logic exp_valid);
        check({tag, "_valid"}, bus.instr_valid, exp_valid);
        check({tag, "_instr"}, bus.instruction, ref_instr);
        check({tag, "_oob"}, bus.instr_oob, ref_oob);
    endtask

    task automatic do_fetch(input int addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr[ADDR_W-1:0];
        predict_fetch(addr);
        step();
        bus.fetch_req = 1'b0;
        check_fetch("fetch", 1'b1);
        step();
        check_fetch("fetch_hold", 1'b0);
    endtask

    // one complete load; words.size() must be <= DEPTH, and == DEPTH when use_last is 0
    task automatic load_seq(input logic [7:0] words[$], input bit use_last,
                            input bit gaps, input bit fetch_too);
        int n;
        int fa;
        n = words.size();
        bus.load_start = 1'b1;
        if (fetch_too) begin
            fa = int'($urandom_range(0, 63));
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = fa[ADDR_W-1:0];
            predict_fetch(fa);
        end
        step();
        bus.load_start = 1'b0;
        bus.fetch_req  = 1'b0;
        if (fetch_too) check_fetch("start_fetch", 1'b1);
        ref_count = 0;
        check("load_ready_on", bus.load_ready, 1'b1);
        check("count_cleared", bus.load_count, ref_count);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    bus.load_valid = 1'b0;
                    bus.load_start = $urandom_range(0, 1);
                    bus.fetch_req  = $urandom_range(0, 1);
                    bus.fetch_addr = 8'($urandom_range(0, 63));
                    step();
                    check("gap_ready", bus.load_ready, 1'b1);
                    check("gap_no_fetch", bus.instr_valid, 1'b0);
                end
                bus.load_start = 1'b0;
                bus.fetch_req  = 1'b0;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = use_last && (i == n - 1);
            step();
            ref_mem[i] = words[i];
            ref_count  = i + 1;
            if (i < n - 1) check("mid_done", bus.load_done, 1'b0);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check("load_done", bus.load_done, 1'b1);
        check("load_count", bus.load_count, ref_count);
        check("ready_off", bus.load_ready, 1'b0);
        check("run_fetch_ready", bus.fetch_ready, 1'b1);
        step();
        check("done_pulse_end", bus.load_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] words[$];
        int a;
        bit r;

        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        check("rst_load_ready", bus.load_ready, 1'b0);
        check("rst_fetch_ready", bus.fetch_ready, 1'b0);
        check("rst_load_count", bus.load_count, 0);
        check("rst_load_done", bus.load_done, 1'b0);
        check_fetch("rst", 1'b0);
        reset_n = 1'b1;

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd0;
        step();
        check("idle_fetch_ready", bus.fetch_ready, 1'b0);
        check_fetch("idle_fetch", 1'b0);
        check("idle_load_ready", bus.load_ready, 1'b0);
        bus.fetch_req = 1'b0;

        words = '{8'h49, 8'h27, 8'h39, 8'h18, 8'h07, 8'h32, 8'h2D, 8'h18, 8'h4D, 8'h1E, 8'hC3};
        load_seq(words, 1'b1, 1'b1, 1'b0);
        do_fetch(0);
        do_fetch(10);

        for (int i = 1; i <= 3; i++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 8'(i);
            predict_fetch(i);
            step();
            check_fetch("b2b", 1'b1);
        end
        bus.fetch_req = 1'b0;
        step();
        check_fetch("b2b_end", 1'b0);

        do_fetch(40);

        words = {};
        for (int i = 0; i < DEPTH; i++) words.push_back(8'(i));
        load_seq(words, 1'b0, 1'b0, 1'b1);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hAA;
        step();
        bus.load_valid = 1'b0;
        check("extra_word_count", bus.load_count, 32);
        check("extra_word_ready", bus.load_ready, 1'b0);
        check("extra_word_done", bus.load_done, 1'b0);
        do_fetch(31);
        do_fetch(0);

        repeat (60) begin
            r = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 63));
            bus.fetch_req  = r;
            bus.fetch_addr = a[ADDR_W-1:0];
            if (r) predict_fetch(a);
            step();
            check_fetch("rand_fetch", r);
        end
        bus.fetch_req = 1'b0;

        repeat (4) begin
            words = {};
            repeat ($urandom_range(1, 31)) words.push_back(8'($urandom));
            load_seq(words, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            repeat (8) do_fetch(int'($urandom_range(0, 63)));
        end

        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            step();
            ref_mem[i] = bus.load_data;
        end
        bus.load_data = 8'hEE;
        bus.load_last = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        ref_instr = 8'h00;
        ref_oob   = 1'b0;
        check("abort_load_ready", bus.load_ready, 1'b0);
        check("abort_fetch_ready", bus.fetch_ready, 1'b0);
        check("abort_count", bus.load_count, 0);
        check("abort_done", bus.load_done, 1'b0);
        check_fetch("abort", 1'b0);
        step();
        check("abort_done_late", bus.load_done, 1'b0);

        words = '{8'h5A, 8'hA5, 8'h3C};
        load_seq(words, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) do_fetch(i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised successor to the fixed 32x8 combinational instruction ROM. It provides a RAM-backed instruction memory that a host fills through a streaming load port. Instructions are then fetched through a registered, one-cycle-latency read port. It sits between the test host/loader and the CPU fetch stage, so programs can change without re-synthesis.

Parameters:
DATA_W, 8, instruction width in bits
ADDR_W, 8, fetch address width
DEPTH, 32, number of stored words; legal range 2 <= DEPTH <= 2^ADDR_W
FILL, 8'h00 (DATA_W bits), value returned for an out-of-range fetch

Ports:
clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
load_start  in  1  begin a new program load (honoured in IDLE or RUN)
load_valid  in  1  load_data is valid this cycle
load_data  in  DATA_W  instruction word to store
load_last  in  1  marks the final word of the load
load_ready  out  1  block accepts load words (high only in LOAD)
load_done  out  1  one-cycle pulse after the final write of a load
load_count  out  ADDR_W+1  number of words written by the most recent load
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch word address
fetch_ready  out  1  fetch accepted this cycle (high only in RUN)
instr_valid  out  1  one-cycle pulse: instruction updated
instruction  out  DATA_W  fetched word; holds until the next accepted fetch
instr_oob  out  1  last accepted fetch had fetch_addr >= DEPTH

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, wptr=0, load_count=0, load_done=0, instr_valid=0, instruction=0, instr_oob=0. Memory array is not cleared.
- load_ready = (state==LOAD). fetch_ready = (state==RUN). Both decode the registered state only.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: load_start -> LOAD with wptr=0. fetch_req is ignored.
  - LOAD: on each edge with load_valid=1, mem[wptr]<=load_data, wptr++, load_count<=wptr+1. Idle cycles (load_valid=0) are tolerated indefinitely.
  - LOAD exit: if the write carries load_last=1, or wptr==DEPTH-1, the next state is RUN. load_done=1 for exactly the following cycle, which is also the first RUN cycle.
  - load_start while in LOAD is ignored.
  - RUN: load_start -> LOAD, wptr=0, load_count=0. A fetch_req in that same cycle is still accepted.
- Fetch: an accepted fetch (fetch_req & fetch_ready) at edge N produces the following at edge N+1:
  - instr_valid=1 for one cycle.
  - instruction = mem[fetch_addr] when fetch_addr<DEPTH, otherwise FILL.
  - instr_oob = (fetch_addr>=DEPTH).
- Throughput is one fetch per cycle. Back-to-back requests produce consecutive instr_valid pulses.
- A non-accepted fetch leaves instruction and instr_oob unchanged, with instr_valid=0.
- Words beyond load_count keep their prior contents. They are unknown after power-up.
- Reset mid-load aborts the load: IDLE, load_count=0, no load_done. Words already written remain in memory.
- Reset wins over every other input in the same cycle.

Optional Feature:
IMEM_WRAP_EN
- Defined: the fetch index is fetch_addr modulo DEPTH. instr_oob is always 0 and FILL is never returned.
- Undefined: out-of-range behaviour is as stated above (FILL with instr_oob=1).
- The macro has no effect on the load path.

Test Plan:
1. Assert reset_n=0 for 2 cycles, release, then fetch_req=1 addr 0 -> fetch_ready=0, instr_valid stays 0, instruction=0, load_ready=0.
2. load_start, then stream 0x49,0x27,0x39,0x18,0x07,0x32,0x2D,0x18,0x4D,0x1E,0xC3 with load_last on the 11th and random 1-3 cycle gaps -> load_done pulse one cycle after the final write, load_count=11. Fetch addr 0 -> 0x49 and addr 10 -> 0xC3, each one cycle later.
3. Back-to-back fetches of addr 1,2,3 -> instr_valid high 3 consecutive cycles with 0x27, 0x39, 0x18.
4. Fetch addr 40 (DEPTH=32) -> instruction=0x00, instr_oob=1. With IMEM_WRAP_EN -> instruction=mem[8]=0x4D, instr_oob=0.
5. Load 32 words (value = index) with no load_last -> automatic RUN after the 32nd write, load_count=32, load_ready=0. A 33rd load_valid is ignored and a fetch of addr 31 returns 31.
6. Drive reset_n=0 after 5 words of a new load -> IDLE, load_count=0, no load_done. Restart the load and confirm a complete 3-word load with load_count=3.
